// File: rtl/sockit_spi_rpk.sv
// Repacks SPI queue chunks (1/2/4 lanes x SDW bits) into right-aligned CDW-bit command words; SOCKIT_SPI_RPK_BUF_EN adds an output word register.
// Latency: a word closes on the edge that fills it (or that takes a lst chunk, or that flushes ahead of an overflow); cmd_req rises one cycle later.
// Backpressure: que_grt drops on overflow and while a closed word cannot leave the accumulator; cmd_req/cmd_ctl/cmd_dat hold until cmd_grt.
module sockit_spi_rpk #(
    parameter int SDW = 8,
    parameter int CDW = 32,
    parameter int QCI = 4,
    parameter int QDW = 4*SDW,
    parameter int CNL = $clog2(CDW/SDW),
    parameter int CCI = CNL+2
) (
    input  logic           clk,
    input  logic           rst,
    output logic           cmd_req,
    output logic [CCI-1:0] cmd_ctl,
    output logic [CDW-1:0] cmd_dat,
    input  logic           cmd_grt,
    input  logic           que_req,
    input  logic [QCI-1:0] que_ctl,
    input  logic [QDW-1:0] que_dat,
    output logic           que_grt
);

    localparam int N = CDW/SDW;
    localparam logic [CNL:0] FUL = (CNL+1)'(N);

    logic [CDW-1:0] acc_dat;
    logic [CNL:0]   acc_fil;
    logic           acc_new, acc_lst, acc_cls;

    logic [QDW-1:0] chunk;
    logic [CNL:0]   units;
    logic [CDW-1:0] shf_dat;
    logic           ovf, que_trn, cmd_trn, acc_clr;

    logic [CDW-1:0] wrk_dat;
    logic [CNL:0]   wrk_fil;
    logic           wrk_new, wrk_lst, wrk_cls;

    logic           evt;
    logic [CDW-1:0] wrd_dat;
    logic [CNL:0]   wrd_fil;
    logic           wrd_new, wrd_lst;

`ifdef SOCKIT_SPI_RPK_BUF_EN
    logic           buf_vld;
    logic [CCI-1:0] buf_ctl;
    logic [CDW-1:0] buf_dat;
`endif

    // Serialised bit order, MSB first: each step takes one bit from every active lane, highest lane first.
    always_comb begin
        chunk   = '0;
        units   = (CNL+1)'(1);
        shf_dat = acc_dat << SDW;
        case (que_ctl[1:0])
            2'd0: chunk[SDW-1:0] = que_dat[SDW-1:0];
            2'd1: chunk[SDW-1:0] = que_dat[2*SDW-1:SDW];
            2'd2: begin
                units   = (CNL+1)'(2);
                shf_dat = acc_dat << (2*SDW);
                for (int k = 0; k < SDW; k++) begin
                    chunk[2*k+1] = que_dat[SDW+k];
                    chunk[2*k]   = que_dat[k];
                end
            end
            default: begin
                units   = (CNL+1)'(4);
                shf_dat = acc_dat << (4*SDW);
                for (int k = 0; k < SDW; k++) begin
                    for (int l = 0; l < 4; l++) begin
                        chunk[4*k+l] = que_dat[l*SDW+k];
                    end
                end
            end
        endcase
    end

    always_comb begin
        wrk_dat = shf_dat | CDW'(chunk);
        wrk_fil = acc_fil + units;
        wrk_new = (acc_fil == '0) ? que_ctl[3] : acc_new;
        wrk_lst = que_ctl[2];
        wrk_cls = (wrk_fil == FUL) | que_ctl[2];
        ovf     = que_req & ~acc_cls & (wrk_fil > FUL);
        que_grt = ~acc_cls & ~ovf;
        que_trn = que_req & que_grt;
        cmd_trn = cmd_req & cmd_grt;
    end

    // Word leaving the accumulator this edge: a stalled closed word, a word closed by this chunk, or an overflow flush.
    always_comb begin
        evt     = 1'b0;
        wrd_dat = acc_dat;
        wrd_fil = acc_fil;
        wrd_new = acc_new;
        wrd_lst = acc_lst;
        if (acc_cls) begin
            evt = 1'b1;
        end else if (que_trn) begin
            evt     = wrk_cls;
            wrd_dat = wrk_dat;
            wrd_fil = wrk_fil;
            wrd_new = wrk_new;
            wrd_lst = wrk_lst;
        end else if (ovf) begin
            evt     = 1'b1;
            wrd_lst = 1'b0;
        end
    end

`ifdef SOCKIT_SPI_RPK_BUF_EN
    always_comb begin
        acc_clr = evt & (~buf_vld | cmd_trn);
        cmd_req = buf_vld;
        cmd_ctl = buf_vld ? buf_ctl : '0;
        cmd_dat = buf_vld ? buf_dat : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_ctl <= '0;
            buf_dat <= '0;
        end else begin
            if (cmd_trn) buf_vld <= 1'b0;
            if (acc_clr) begin
                buf_vld <= 1'b1;
                buf_ctl <= {wrd_new, wrd_lst, wrd_fil[CNL-1:0] - CNL'(1)};
                buf_dat <= wrd_dat;
            end
        end
    end
`else
    always_comb begin
        acc_clr = cmd_trn;
        cmd_req = acc_cls;
        cmd_ctl = acc_cls ? {acc_new, acc_lst, acc_fil[CNL-1:0] - CNL'(1)} : '0;
        cmd_dat = acc_cls ? acc_dat : '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_dat <= '0;
            acc_fil <= '0;
            acc_new <= 1'b0;
            acc_lst <= 1'b0;
            acc_cls <= 1'b0;
        end else if (acc_clr) begin
            acc_dat <= '0;
            acc_fil <= '0;
            acc_new <= 1'b0;
            acc_lst <= 1'b0;
            acc_cls <= 1'b0;
        end else if (evt) begin
            acc_dat <= wrd_dat;
            acc_fil <= wrd_fil;
            acc_new <= wrd_new;
            acc_lst <= wrd_lst;
            acc_cls <= 1'b1;
        end else if (que_trn) begin
            acc_dat <= wrk_dat;
            acc_fil <= wrk_fil;
            acc_new <= wrk_new;
            acc_lst <= wrk_lst;
        end
    end

endmodule

// File: tb/tb_sockit_spi_rpk.sv
// Scoreboard bench for sockit_spi_rpk (default parameters, N=4 units per word).
module tb_sockit_spi_rpk;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_req;
    logic [3:0]  cmd_ctl;
    logic [31:0] cmd_dat;
    logic        cmd_grt;
    logic        que_req;
    logic [3:0]  que_ctl;
    logic [31:0] que_dat;
    logic        que_grt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];

    always #5 clk = ~clk;

    sockit_spi_rpk dut (
        .clk     (clk),
        .rst     (rst),
        .cmd_req (cmd_req),
        .cmd_ctl (cmd_ctl),
        .cmd_dat (cmd_dat),
        .cmd_grt (cmd_grt),
        .que_req (que_req),
        .que_ctl (que_ctl),
        .que_dat (que_dat),
        .que_grt (que_grt)
    );

    always @(negedge clk) begin
        if (rst === 1'b1 && cmd_req === 1'b1 && cmd_grt === 1'b1)
            obs_q.push_back({cmd_ctl, cmd_dat});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Quad bit order: step i (MSB first) emits lane3..lane0 bit (7-i).
    function automatic logic [31:0] quad_il(input logic [31:0] d);
        logic [31:0] r;
        int p;
        r = '0;
        p = 31;
        for (int i = 0; i < 8; i++) begin
            for (int j = 3; j >= 0; j--) begin
                r[p] = d[j*8 + 7 - i];
                p--;
            end
        end
        return r;
    endfunction

    task automatic que_send(input logic [3:0] ctl, input logic [31:0] dat, output int waits);
        int n = 0;
        que_req = 1'b1;
        que_ctl = ctl;
        que_dat = dat;
        @(negedge clk);
        while (que_grt !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (que_grt !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL que_send_timeout: que_grt=%b, required 1", que_grt);
        end
        @(posedge clk); #1;
        que_req = 1'b0;
        waits = n;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (obs_q.size() < n && t < 200);
        #1;
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_grt = 1'b1;
        que_req = 1'b0; que_ctl = '0; que_dat = '0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_req: got %b, required 0", cmd_req); end
        n_cmp++; if (cmd_ctl !== 4'h0) begin n_bad++; $display("FAIL reset_cmd_ctl: got %h, required 0", cmd_ctl); end
        n_cmp++; if (cmd_dat !== 32'h0) begin n_bad++; $display("FAIL reset_cmd_dat: got %h, required 0", cmd_dat); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (que_grt !== 1'b1) begin n_bad++; $display("FAIL reset_que_grt: got %b, required 1", que_grt); end
    endtask

    task automatic test_quad();
        int w; bit ok; logic [35:0] e, g;
        exp_q.push_back({4'hF, 32'hCCCC_3333});
        que_send(4'b1111, 32'hF0F0_0F0F, w);
        @(negedge clk);
        n_cmp++; if (cmd_req !== 1'b1) begin n_bad++; $display("FAIL quad_latency: cmd_req=%b one cycle after close, required 1", cmd_req); end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL quad: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL quad: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_spi();
        int w; bit ok; logic [35:0] e, g;
        logic [7:0] b1 [4];
        logic [7:0] b0 [4];
        b1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        b0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back({4'hF, 32'hA1B2_C3D4});
        exp_q.push_back({4'h3, 32'h1122_3344});
        for (int i = 0; i < 4; i++)
            que_send((i == 0) ? 4'b1001 : (i == 3) ? 4'b0101 : 4'b0001, {16'h5A3C, b1[i], 8'hE7}, w);
        for (int i = 0; i < 4; i++)
            que_send((i == 0) ? 4'b0000 : 4'b1000, {16'hC3A5, 8'h99, b0[i]}, w);
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL spi: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL spi: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_dual();
        int w; bit ok; logic [35:0] e, g;
        exp_q.push_back({4'hF, 32'hAAAA_0055});
        que_send(4'b1010, {16'h1234, 8'hFF, 8'h00}, w);
        que_send(4'b0110, {16'hABCD, 8'h00, 8'h0F}, w);
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL dual: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL dual: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_overflow();
        int w, exp_w; bit ok; logic [35:0] e, g;
`ifdef SOCKIT_SPI_RPK_BUF_EN
        exp_w = 1;
`else
        exp_w = 2;
`endif
        exp_q.push_back({4'h9, 32'h0000_1234});
        exp_q.push_back({4'hF, 32'hCCCC_CCCC});
        que_send(4'b1000, {24'h6B6B6B, 8'h12}, w);
        que_send(4'b0000, {24'h6B6B6B, 8'h34}, w);
        que_send(4'b1111, 32'hFFFF_0000, w);
        n_cmp++; if (w != exp_w) begin n_bad++; $display("FAIL overflow_grt_low: %0d cycles, required %0d", w, exp_w); end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL overflow: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL overflow: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_stall();
        int w; bit ok; logic exp_g; logic [35:0] e, g;
        logic [7:0] ba [4];
        logic [7:0] bb [4];
        ba = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        bb = '{8'h01, 8'h02, 8'h03, 8'h04};
`ifdef SOCKIT_SPI_RPK_BUF_EN
        exp_g = 1'b1;
`else
        exp_g = 1'b0;
`endif
        cmd_grt = 1'b0;
        exp_q.push_back({4'hB, 32'h5A6B_7C8D});
        exp_q.push_back({4'h7, 32'h0102_0304});
        for (int i = 0; i < 4; i++)
            que_send((i == 0) ? 4'b1000 : 4'b0000, {16'h0, 8'h77, ba[i]}, w);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (cmd_req !== 1'b1) begin n_bad++; $display("FAIL stall_req c%0d: got %b, required 1", c, cmd_req); end
            n_cmp++; if (cmd_ctl !== 4'hB) begin n_bad++; $display("FAIL stall_ctl c%0d: got %h, required b", c, cmd_ctl); end
            n_cmp++; if (cmd_dat !== 32'h5A6B_7C8D) begin n_bad++; $display("FAIL stall_dat c%0d: got %h, required 5a6b7c8d", c, cmd_dat); end
        end
        n_cmp++; if (que_grt !== exp_g) begin n_bad++; $display("FAIL stall_que_grt: got %b, required %b", que_grt, exp_g); end
        @(posedge clk); #1;
`ifdef SOCKIT_SPI_RPK_BUF_EN
        for (int i = 0; i < 4; i++)
            que_send((i == 3) ? 4'b0100 : 4'b0000, {16'h0, 8'h77, bb[i]}, w);
        @(negedge clk);
        n_cmp++; if (que_grt !== 1'b0) begin n_bad++; $display("FAIL stall_full_grt: got %b, required 0", que_grt); end
        n_cmp++; if (cmd_dat !== 32'h5A6B_7C8D) begin n_bad++; $display("FAIL stall_full_dat: got %h, required 5a6b7c8d", cmd_dat); end
        @(posedge clk); #1;
        cmd_grt = 1'b1;
`else
        cmd_grt = 1'b1;
        for (int i = 0; i < 4; i++)
            que_send((i == 3) ? 4'b0100 : 4'b0000, {16'h0, 8'h77, bb[i]}, w);
`endif
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL stall: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL stall: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_reset_mid();
        int w; bit ok; logic [35:0] e, g;
        logic [7:0] bn [4];
        bn = '{8'h31, 8'h42, 8'h53, 8'h64};
        que_send(4'b1001, {16'h0, 8'hAA, 8'h00}, w);
        que_send(4'b0001, {16'h0, 8'hBB, 8'h00}, w);
        rst = 1'b0;
        #2;
        n_cmp++; if (cmd_req !== 1'b0) begin n_bad++; $display("FAIL midrst_cmd_req: got %b, required 0", cmd_req); end
        n_cmp++; if (cmd_ctl !== 4'h0) begin n_bad++; $display("FAIL midrst_cmd_ctl: got %h, required 0", cmd_ctl); end
        n_cmp++; if (cmd_dat !== 32'h0) begin n_bad++; $display("FAIL midrst_cmd_dat: got %h, required 0", cmd_dat); end
        n_cmp++; if (que_grt !== 1'b1) begin n_bad++; $display("FAIL midrst_que_grt: got %b, required 1", que_grt); end
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({4'hB, 32'h3142_5364});
        for (int i = 0; i < 4; i++)
            que_send((i == 0) ? 4'b1001 : 4'b0001, {16'h0, bn[i], 8'h00}, w);
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_mid: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL reset_mid: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int w, tot, exp_tot; bit ok; logic [31:0] d; logic [35:0] e, g;
`ifdef SOCKIT_SPI_RPK_BUF_EN
        exp_tot = 0;
`else
        exp_tot = 5;
`endif
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            exp_q.push_back({4'hB, quad_il(d)});
            que_send(4'b1011, d, w);
            tot += w;
        end
        n_cmp++; if (tot != exp_tot) begin n_bad++; $display("FAIL b2b_bubbles: %0d grant-low cycles, required %0d", tot, exp_tot); end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL b2b: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL b2b: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
    endtask

    task automatic test_random();
        int w, fil; bit ok; logic [35:0] e, g;
        logic [31:0] acc, jk, dat;
        logic [7:0] b;
        logic nw, nwb, lst, iom;
        fil = 0; acc = '0; nw = 1'b0;
        for (int i = 0; i < 24; i++) begin
            b   = 8'($urandom_range(0, 255));
            lst = (i == 23) || ($urandom_range(0, 3) == 0);
            nwb = 1'($urandom_range(0, 1));
            iom = 1'($urandom_range(0, 1));
            jk  = $urandom;
            dat = iom ? {jk[31:16], b, jk[7:0]} : {jk[31:8], b};
            if (fil == 0) nw = nwb;
            acc = {acc[23:0], b};
            fil++;
            if (fil == 4 || lst) begin
                exp_q.push_back({nw, lst, 2'(fil - 1), acc});
                fil = 0;
                acc = '0;
            end
            que_send({nwb, lst, 1'b0, iom}, dat, w);
        end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL random: %0d words seen, required %0d", obs_q.size(), exp_q.size());
            exp_q.delete(); obs_q.delete();
        end else while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front(); n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL random: got ctl=%h dat=%h, required ctl=%h dat=%h", g[35:32], g[31:0], e[35:32], e[31:0]); end
        end
        repeat (5) @(posedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL extra_words: %0d unexpected words, required 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_quad();
        test_spi();
        test_dual();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
